// File: rtl/ifm_pkg.sv
// Shared types and helpers for the instruction fetch memory: FSM states,
// fault classification and the default NOP encoding.
package ifm_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ifm_state_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISALIGNED = 2'd1,
        FC_RANGE      = 2'd2,
        FC_UNLOADED   = 2'd3
    } fault_cause_e;

    // Classify a fetch; the full 30-bit word index is compared so high addresses never alias.
    function automatic fault_cause_e fault_cause(input logic [ADDR_W-1:0] addr,
                                                 input logic [31:0]       loaded,
                                                 input int unsigned       depth);
        logic [31:0] idx;
        idx = {2'b00, addr[ADDR_W-1:2]};
        if (addr[1:0] != 2'b00) begin
            return FC_MISALIGNED;
        end
        if (idx >= depth) begin
            return FC_RANGE;
        end
        if (idx >= loaded) begin
            return FC_UNLOADED;
        end
        return FC_NONE;
    endfunction

endpackage

// File: rtl/instruction_fetch_memory_if.sv
// Fetch-side request/response bus between the fetch stage (master) and the
// instruction memory (slave).
interface instruction_fetch_memory_if
    import ifm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic              ReqValid;
    logic              ReqReady;
    logic [ADDR_W-1:0] Address;
    logic              RespValid;
    logic              RespReady;
    logic [WIDTH-1:0]  Instruction;
    logic              Fault;

    modport master (
        output ReqValid,
        output Address,
        output RespReady,
        input  ReqReady,
        input  RespValid,
        input  Instruction,
        input  Fault
    );

    modport slave (
        input  ReqValid,
        input  Address,
        input  RespReady,
        output ReqReady,
        output RespValid,
        output Instruction,
        output Fault
    );

endinterface

// File: rtl/ifm_ram_1r1w.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// The read register only updates on rd_en_i so it holds while a response stalls.
module ifm_ram_1r1w #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_fetch_memory.sv
// Loadable instruction memory: program streamed in during LOAD, then served
// through a registered valid/ready fetch port in RUN with NOP+Fault on bad fetches.
module instruction_fetch_memory
    import ifm_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 128,
    parameter int unsigned      AW       = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_DEFAULT)
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       LoadValid,
    input  logic [WIDTH-1:0]           LoadData,
    input  logic                       LoadDone,
    output logic                       LoadFull,
    output logic [AW:0]                LoadCount,
    instruction_fetch_memory_if.slave  fetch
);

    localparam int unsigned CW = AW + 1;

    ifm_state_e   state_q, state_d;
    logic [CW-1:0] load_count_q, load_count_d;
    logic         load_full_q, load_full_d;
    logic         resp_valid_q, resp_valid_d;
    logic         nop_sel_q, nop_sel_d;
    logic         fault_q, fault_d;

    logic         req_ready_c;
    logic         accept_c;
    logic         wr_en_c;
    logic         rd_en_c;
    fault_cause_e cause_c;
    logic [AW-1:0] wr_addr_c;
    logic [AW-1:0] rd_addr_c;
    logic [WIDTH-1:0] rd_data;

    assign wr_addr_c = load_count_q[AW-1:0];
    assign rd_addr_c = fetch.Address[AW+1:2];

    // Next-state, handshake and fault classification.
    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        resp_valid_d = resp_valid_q;
        nop_sel_d    = nop_sel_q;
        fault_d      = fault_q;
        req_ready_c  = 1'b0;
        accept_c     = 1'b0;
        wr_en_c      = 1'b0;
        rd_en_c      = 1'b0;
        cause_c      = fault_cause(fetch.Address, 32'(load_count_q), DEPTH);

        case (state_q)
            ST_LOAD: begin
                wr_en_c = LoadValid && !load_full_q;
                if (wr_en_c) begin
                    load_count_d = load_count_q + CW'(1);
                end
                if (LoadDone) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready_c = !resp_valid_q || fetch.RespReady;
                accept_c    = fetch.ReqValid && req_ready_c;
                if (accept_c) begin
                    resp_valid_d = 1'b1;
                    nop_sel_d    = (cause_c != FC_NONE);
                    fault_d      = (cause_c != FC_NONE);
                    rd_en_c      = (cause_c == FC_NONE);
                end else if (fetch.RespReady) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        load_full_d = (load_count_d == CW'(DEPTH));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_LOAD;
            load_count_q <= '0;
            load_full_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            nop_sel_q    <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            load_full_q  <= load_full_d;
            resp_valid_q <= resp_valid_d;
            nop_sel_q    <= nop_sel_d;
            fault_q      <= fault_d;
        end
    end

    ifm_ram_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (Clk),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_addr_c),
        .wr_data_i (LoadData),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data)
    );

    // nop_sel_q masks the un-reset read register until a real word has been read.
    assign fetch.ReqReady    = req_ready_c;
    assign fetch.RespValid   = resp_valid_q;
    assign fetch.Instruction = nop_sel_q ? NOP_WORD : rd_data;
    assign fetch.Fault       = fault_q;
    assign LoadFull          = load_full_q;
    assign LoadCount         = load_count_q;

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised, synchronous instruction memory for the MIPS datapath, the next generation of the hard-coded combinational instruction store. A program is streamed in word-by-word after reset (LOAD phase), then the fetch stage reads it through a registered, valid/ready-handshaked port (RUN phase). Out-of-range, misaligned and not-yet-loaded fetches return a NOP and raise a fault flag instead of aliasing.

## Interface
Parameters:
- WIDTH, 32, instruction word width in bits
- DEPTH, 128, number of words; need not be a power of two
- AW, $clog2(DEPTH), derived index width; not overridden
- NOP_WORD, 32'h0000_0000, word returned on any fault

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- LoadValid  in  1  a program word is presented on LoadData
- LoadData  in  WIDTH  program word, written at the internal load pointer
- LoadDone  in  1  one-cycle pulse ending the LOAD phase
- LoadFull  out  1  load pointer has reached DEPTH
- LoadCount  out  AW+1  number of words loaded since reset
- ReqValid  in  1  fetch request valid
- ReqReady  out  1  fetch request accepted when ReqValid && ReqReady
- Address  in  32  byte address of requested instruction
- RespValid  out  1  Instruction/Fault hold a valid response
- RespReady  in  1  fetch stage consumes the response
- Instruction  out  WIDTH  fetched word
- Fault  out  1  response is a fault (Instruction = NOP_WORD)

## Operation
- States: LOAD (reset state), RUN. LOAD -> RUN on LoadDone. RUN -> LOAD only via Reset.
- LOAD: each cycle with LoadValid && !LoadFull writes LoadData to word LoadCount, LoadCount increments. LoadValid while LoadFull: data dropped, count unchanged. ReqReady = 0.
- LoadValid and LoadDone in the same cycle: the word is written, then the state moves to RUN.
- RUN: LoadValid ignored; memory is read-only. ReqReady = !RespValid || RespReady.
- Accepted request: word index = Address[31:2] (full 30 bits compared, no truncation).
- Fault if Address[1:0] != 0, index >= DEPTH, or index >= LoadCount; then Instruction = NOP_WORD, Fault = 1. Otherwise Instruction = memory[index], Fault = 0.
- Response register: RespValid set on an accepted request; cleared on RespValid && RespReady with no new accept; a consume-and-accept in the same cycle replaces the response back-to-back.
- Instruction/Fault stable while RespValid && !RespReady.
- Reset values: state LOAD, LoadCount 0, LoadFull 0, ReqReady 0, RespValid 0, Instruction NOP_WORD, Fault 0. Array contents are not cleared; they become unreachable because LoadCount = 0.
- Reset mid-load or mid-run: any pending response is discarded, and the program must be reloaded.

## Timing
- Read latency: 1 cycle; a request accepted at edge N shows RespValid at N+1 with data.
- Throughput: 1 fetch/cycle while RespReady is held high.
- The first possible request accept is the cycle after LoadDone.
- LoadFull asserts the cycle after the DEPTH-th write. LoadCount is registered and updates the cycle after each write.
- No combinational path from Address to Instruction. ReqReady depends combinationally on RespReady only.

## Structure
- Package ifm_pkg: state enum {LOAD, RUN}, fault-cause helper function, default NOP constant.
- Sub-module ifm_ram_1r1w: DEPTH x WIDTH array, one write port (load) and one synchronous read port (fetch). Fault muxing and the handshake stay in the top level.

## Test plan
- Reset, load 4 words (0x20080001, 0x20090002, 0x200A0003, 0x200B0004), LoadDone, fetch 0x0,0x4,0x8,0xC with RespReady=1 -> four back-to-back responses with those words, Fault=0, 1-cycle latency.
- Hold RespReady=0 after the first response -> ReqReady=0, Instruction stays 0x20080001 and RespValid stays 1 until release; there is no loss or duplication.
- After loading 4 words, fetch 0x10 (unloaded), 0x2 (misaligned), 0x200 with DEPTH=128 (out of range), 0x1_0000_0000-aliased 0x80000000 -> each gives Instruction=0, Fault=1.
- DEPTH=8: stream 10 words -> LoadFull=1 after the 8th, LoadCount=8, words 9-10 dropped. Fetching 0x1C returns word 8.
- ReqValid during LOAD -> never accepted. Reset asserted with RespValid=1 mid-run -> the next cycle has RespValid=0, state LOAD, LoadCount=0, and fetching 0x0 after LoadDone with no loads gives Fault=1.
